// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM stage: bus widths, command codes,
// FSM state encoding and small command-decode helpers (including MemLen).
package mem_stage_pkg;

    localparam int Cmd_Typebus = 6;
    localparam int RegAddrBus  = 5;
    localparam int RegBus      = 32;

    // Command codes carried from EX/MEM; 0 is a bubble.
    localparam logic [Cmd_Typebus-1:0] CmdNOP   = 6'd0;
    localparam logic [Cmd_Typebus-1:0] CmdLUI   = 6'd1;
    localparam logic [Cmd_Typebus-1:0] CmdAUIPC = 6'd2;
    localparam logic [Cmd_Typebus-1:0] CmdJAL   = 6'd3;
    localparam logic [Cmd_Typebus-1:0] CmdJALR  = 6'd4;
    localparam logic [Cmd_Typebus-1:0] CmdBEQ   = 6'd5;
    localparam logic [Cmd_Typebus-1:0] CmdBNE   = 6'd6;
    localparam logic [Cmd_Typebus-1:0] CmdBLT   = 6'd7;
    localparam logic [Cmd_Typebus-1:0] CmdBGE   = 6'd8;
    localparam logic [Cmd_Typebus-1:0] CmdBLTU  = 6'd9;
    localparam logic [Cmd_Typebus-1:0] CmdBGEU  = 6'd10;
    localparam logic [Cmd_Typebus-1:0] CmdLB    = 6'd11;
    localparam logic [Cmd_Typebus-1:0] CmdLH    = 6'd12;
    localparam logic [Cmd_Typebus-1:0] CmdLW    = 6'd13;
    localparam logic [Cmd_Typebus-1:0] CmdLBU   = 6'd14;
    localparam logic [Cmd_Typebus-1:0] CmdLHU   = 6'd15;
    localparam logic [Cmd_Typebus-1:0] CmdSB    = 6'd16;
    localparam logic [Cmd_Typebus-1:0] CmdSH    = 6'd17;
    localparam logic [Cmd_Typebus-1:0] CmdSW    = 6'd18;
    localparam logic [Cmd_Typebus-1:0] CmdADDI  = 6'd19;
    localparam logic [Cmd_Typebus-1:0] CmdSLTI  = 6'd20;
    localparam logic [Cmd_Typebus-1:0] CmdSLTIU = 6'd21;
    localparam logic [Cmd_Typebus-1:0] CmdXORI  = 6'd22;
    localparam logic [Cmd_Typebus-1:0] CmdORI   = 6'd23;
    localparam logic [Cmd_Typebus-1:0] CmdANDI  = 6'd24;
    localparam logic [Cmd_Typebus-1:0] CmdSLLI  = 6'd25;
    localparam logic [Cmd_Typebus-1:0] CmdSRLI  = 6'd26;
    localparam logic [Cmd_Typebus-1:0] CmdSRAI  = 6'd27;
    localparam logic [Cmd_Typebus-1:0] CmdADD   = 6'd28;
    localparam logic [Cmd_Typebus-1:0] CmdSUB   = 6'd29;
    localparam logic [Cmd_Typebus-1:0] CmdSLL   = 6'd30;
    localparam logic [Cmd_Typebus-1:0] CmdSLT   = 6'd31;
    localparam logic [Cmd_Typebus-1:0] CmdSLTU  = 6'd32;
    localparam logic [Cmd_Typebus-1:0] CmdXOR   = 6'd33;
    localparam logic [Cmd_Typebus-1:0] CmdSRL   = 6'd34;
    localparam logic [Cmd_Typebus-1:0] CmdSRA   = 6'd35;
    localparam logic [Cmd_Typebus-1:0] CmdOR    = 6'd36;
    localparam logic [Cmd_Typebus-1:0] CmdAND   = 6'd37;

    // Highest defined code; anything above is treated as a bubble.
    localparam logic [Cmd_Typebus-1:0] CmdLast  = CmdAND;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } mem_state_e;

    // Byte count of a memory command; 0 for anything that is not a load/store.
    function automatic logic [2:0] MemLen(input logic [Cmd_Typebus-1:0] cmd);
        logic [2:0] len;
        case (cmd)
            CmdLB, CmdLBU, CmdSB: len = 3'd1;
            CmdLH, CmdLHU, CmdSH: len = 3'd2;
            CmdLW, CmdSW:         len = 3'd4;
            default:              len = 3'd0;
        endcase
        return len;
    endfunction

    function automatic logic is_load_cmd(input logic [Cmd_Typebus-1:0] cmd);
        return (cmd == CmdLB) || (cmd == CmdLH) || (cmd == CmdLW) ||
               (cmd == CmdLBU) || (cmd == CmdLHU);
    endfunction

    function automatic logic is_store_cmd(input logic [Cmd_Typebus-1:0] cmd);
        return (cmd == CmdSB) || (cmd == CmdSH) || (cmd == CmdSW);
    endfunction

    // Any defined, non-bubble command.
    function automatic logic is_known_cmd(input logic [Cmd_Typebus-1:0] cmd);
        return (cmd != CmdNOP) && (cmd <= CmdLast);
    endfunction

    // Halfword on odd address or word not on a 4-byte boundary.
    function automatic logic mem_misaligned(input logic [Cmd_Typebus-1:0] cmd,
                                            input logic [1:0]             addr_lo);
        logic bad;
        case (cmd)
            CmdLH, CmdLHU, CmdSH: bad = addr_lo[0];
            CmdLW, CmdSW:         bad = (addr_lo != 2'b00);
            default:              bad = 1'b0;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/mem_stage_load_extend.sv
// Load data extension: turns the assembled little-endian bytes into the
// 32-bit register value, sign- or zero-extending from bit 8*len-1.
module mem_stage_load_extend
    import mem_stage_pkg::*;
(
    input  logic [Cmd_Typebus-1:0] cmdtype,
    input  logic [RegBus-1:0]      acc,
    output logic [RegBus-1:0]      ext_data
);

    // Pick the extension according to the load flavour; words pass unchanged.
    always_comb begin
        ext_data = acc;
        case (cmdtype)
            CmdLB:   ext_data = {{24{acc[7]}}, acc[7:0]};
            CmdLBU:  ext_data = {24'd0, acc[7:0]};
            CmdLH:   ext_data = {{16{acc[15]}}, acc[15:0]};
            CmdLHU:  ext_data = {16'd0, acc[15:0]};
            default: ext_data = acc;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// MEM stage of the RV32I pipeline. Loads and stores run as byte-serial
// transactions on an 8-bit memory port (IDLE -> ACCESS -> DONE) while the
// upstream stages are stalled; everything else passes straight through.
// Optional feature macro: MEM_MISALIGN_CHECK_EN adds misalign_o and skips
// misaligned halfword/word accesses instead of servicing them.
module mem_stage
    import mem_stage_pkg::*;
(
    input  logic                   clk_in,
    input  logic                   rst_in,
    input  logic [Cmd_Typebus-1:0] cmdtype_i,
    input  logic [RegBus-1:0]      alu_result_i,
    input  logic [RegBus-1:0]      store_data_i,
    input  logic [RegAddrBus-1:0]  rd_i,
    input  logic                   write_rd_i,
    output logic                   mem_req_o,
    output logic                   mem_wr_o,
    output logic [RegBus-1:0]      mem_addr_o,
    output logic [7:0]             mem_wdata_o,
    input  logic                   mem_ack_i,
    input  logic [7:0]             mem_rdata_i,
    output logic                   wb_write_o,
    output logic [RegAddrBus-1:0]  wb_rd_o,
    output logic [RegBus-1:0]      wb_data_o,
    output logic                   mem_forward_id_o,
    output logic [RegAddrBus-1:0]  mem_forward_addr_o,
    output logic [RegBus-1:0]      mem_forward_data_o,
    output logic                   stall_from_mem_o
`ifdef MEM_MISALIGN_CHECK_EN
    ,
    output logic                   misalign_o
`endif
);

    mem_state_e        state_reg;
    logic [1:0]        cnt_reg;
    logic [RegBus-1:0] acc_reg;

    logic [2:0]        len;
    logic              is_mem;
    logic              is_load;
    logic              is_store;
    logic              is_known;
    logic              last_byte;
    logic              take_misalign;
    logic              skip_wb;
    logic [RegBus-1:0] ext_data;

    assign len       = MemLen(cmdtype_i);
    assign is_load   = is_load_cmd(cmdtype_i);
    assign is_store  = is_store_cmd(cmdtype_i);
    assign is_mem    = is_load | is_store;
    assign is_known  = is_known_cmd(cmdtype_i);
    assign last_byte = ({1'b0, cnt_reg} == (len - 3'd1));

`ifdef MEM_MISALIGN_CHECK_EN
    logic misalign_reg;

    assign take_misalign = mem_misaligned(cmdtype_i, alu_result_i[1:0]);

    // Flag is high exactly in the DONE cycle that follows a skipped access.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            misalign_reg <= 1'b0;
        end else begin
            misalign_reg <= (state_reg == ST_IDLE) && is_mem && take_misalign;
        end
    end

    assign misalign_o = misalign_reg;
    assign skip_wb    = misalign_reg;
`else
    assign take_misalign = 1'b0;
    assign skip_wb       = 1'b0;
`endif

    // Byte-serial access sequencer: counts acked bytes and assembles read data.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= 2'd0;
            acc_reg   <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (is_mem) begin
                        cnt_reg   <= 2'd0;
                        acc_reg   <= '0;
                        state_reg <= take_misalign ? ST_DONE : ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    if (mem_ack_i) begin
                        if (is_load) begin
                            acc_reg[{cnt_reg, 3'b000} +: 8] <= mem_rdata_i;
                        end
                        cnt_reg <= cnt_reg + 2'd1;
                        if (last_byte) begin
                            state_reg <= ST_DONE;
                        end
                    end
                end
                // Upstream advances on this same edge, so DONE lasts one cycle.
                ST_DONE: state_reg <= ST_IDLE;
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    mem_stage_load_extend u_load_extend (
        .cmdtype  (cmdtype_i),
        .acc      (acc_reg),
        .ext_data (ext_data)
    );

    // Output decode from state; everything is forced low while reset is held
    // so an abandoned access drops its request immediately.
    always_comb begin
        mem_req_o        = 1'b0;
        mem_wr_o         = 1'b0;
        mem_addr_o       = '0;
        mem_wdata_o      = 8'd0;
        wb_write_o       = 1'b0;
        wb_rd_o          = '0;
        wb_data_o        = '0;
        stall_from_mem_o = 1'b0;
        if (rst_in) begin
            case (state_reg)
                ST_IDLE: begin
                    if (is_mem) begin
                        stall_from_mem_o = 1'b1;
                    end else if (is_known) begin
                        wb_write_o = write_rd_i;
                        wb_rd_o    = rd_i;
                        wb_data_o  = alu_result_i;
                    end
                end
                ST_ACCESS: begin
                    mem_req_o        = 1'b1;
                    mem_wr_o         = is_store;
                    mem_addr_o       = alu_result_i + {30'd0, cnt_reg};
                    mem_wdata_o      = store_data_i[{cnt_reg, 3'b000} +: 8];
                    stall_from_mem_o = 1'b1;
                end
                ST_DONE: begin
                    if (is_load && !skip_wb) begin
                        wb_write_o = write_rd_i;
                        wb_rd_o    = rd_i;
                        wb_data_o  = ext_data;
                    end
                end
                default: ;
            endcase
        end
    end

    // Forwarding to decode mirrors the write-back triple; x0 is never forwarded.
    assign mem_forward_id_o   = wb_write_o && (wb_rd_o != '0);
    assign mem_forward_addr_o = wb_rd_o;
    assign mem_forward_data_o = wb_data_o;

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: a vector table driven through a byte-wide memory
// responder, expected results queued at issue and checked at completion,
// plus hand-written reset sequences.
`timescale 1ns/1ps
module tb_mem_stage;
    import mem_stage_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [5:0]  cmd;
    logic [31:0] alu;
    logic [31:0] sdata;
    logic [4:0]  rd;
    logic        wrd;
    logic        mem_req;
    logic        mem_wr;
    logic [31:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        ack;
    logic [7:0]  rdata;
    logic        wb_write;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        fwd;
    logic [4:0]  fwd_addr;
    logic [31:0] fwd_data;
    logic        stall;
`ifdef MEM_MISALIGN_CHECK_EN
    logic        misalign;
`endif

    logic [7:0] tb_mem [0:4095];
    assign rdata = tb_mem[mem_addr[11:0]];

    always #5 clk = ~clk;

    mem_stage dut (
        .clk_in             (clk),
        .rst_in             (rst_n),
        .cmdtype_i          (cmd),
        .alu_result_i       (alu),
        .store_data_i       (sdata),
        .rd_i               (rd),
        .write_rd_i         (wrd),
        .mem_req_o          (mem_req),
        .mem_wr_o           (mem_wr),
        .mem_addr_o         (mem_addr),
        .mem_wdata_o        (mem_wdata),
        .mem_ack_i          (ack),
        .mem_rdata_i        (rdata),
        .wb_write_o         (wb_write),
        .wb_rd_o            (wb_rd),
        .wb_data_o          (wb_data),
        .mem_forward_id_o   (fwd),
        .mem_forward_addr_o (fwd_addr),
        .mem_forward_data_o (fwd_data),
        .stall_from_mem_o   (stall)
`ifdef MEM_MISALIGN_CHECK_EN
        ,
        .misalign_o         (misalign)
`endif
    );

    typedef struct {
        string       name;
        logic [5:0]  cmd;
        logic [31:0] addr;
        logic [31:0] sdata;
        logic [4:0]  rd;
        logic        wrd;
        logic        preload;
        logic [31:0] bytes;
        int          hold_byte;
        int          hold_n;
        logic        exp_write;
        logic [31:0] exp_data;
        int          exp_stall;
        int          exp_len;
    } vec_t;

    typedef struct {
        logic        write;
        logic [4:0]  rd;
        logic [31:0] data;
        logic        fwd;
        int          stall;
        int          reqs;
        int          wrs;
        logic        misal;
    } exp_t;

    exp_t sb_q[$];
    vec_t tv[17];
    int   checks   = 0;
    int   failures = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got=%h want=%h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input string n, input logic [5:0] c, input logic [31:0] a,
                                input logic [31:0] sd, input logic [4:0] r, input logic w,
                                input logic pl, input logic [31:0] b, input int hb, input int hn,
                                input logic ew, input logic [31:0] ed, input int es, input int el);
        vec_t v;
        v.name = n; v.cmd = c; v.addr = a; v.sdata = sd; v.rd = r; v.wrd = w;
        v.preload = pl; v.bytes = b; v.hold_byte = hb; v.hold_n = hn;
        v.exp_write = ew; v.exp_data = ed; v.exp_stall = es; v.exp_len = el;
        return v;
    endfunction

`ifdef MEM_MISALIGN_CHECK_EN
    function automatic logic tb_misal(input logic [5:0] c, input logic [31:0] a);
        if (c == CmdLH || c == CmdLHU || c == CmdSH) return a[0];
        if (c == CmdLW || c == CmdSW) return a[1:0] != 2'b00;
        return 1'b0;
    endfunction
`endif

    task automatic apply(input vec_t v);
        exp_t e;
        int   acks;
        int   lows;
        int   stall_n;
        int   reqs;
        int   wrs;
        logic done;
        logic st;

        st = (v.cmd == CmdSB) || (v.cmd == CmdSH) || (v.cmd == CmdSW);
        if (v.preload) begin
            for (int i = 0; i < 4; i++) begin
                logic [31:0] a;
                a = v.addr + i;
                tb_mem[a[11:0]] = v.bytes[8*i +: 8];
            end
        end

        e.write = v.exp_write;
        e.rd    = v.rd;
        e.data  = v.exp_data;
        e.stall = v.exp_stall;
        e.reqs  = v.exp_len + v.hold_n;
        e.wrs   = st ? v.exp_len : 0;
        e.misal = 1'b0;
`ifdef MEM_MISALIGN_CHECK_EN
        if (tb_misal(v.cmd, v.addr)) begin
            e.misal = 1'b1; e.write = 1'b0; e.stall = 1; e.reqs = 0; e.wrs = 0;
        end
`endif
        e.fwd = e.write && (v.rd != 5'd0);

        @(posedge clk);
        #1;
        cmd = v.cmd; alu = v.addr; sdata = v.sdata; rd = v.rd; wrd = v.wrd; ack = 1'b0;
        sb_q.push_back(e);

        done = 1'b0; acks = 0; lows = 0; stall_n = 0; reqs = 0; wrs = 0;
        for (int cyc = 0; cyc < 40 && !done; cyc++) begin
            @(negedge clk);
            if (stall) begin
                stall_n++;
                chk({v.name, "_wb_during_stall"}, {30'd0, wb_write, fwd}, 32'd0);
            end
            if (mem_req) begin
                reqs++;
                chk({v.name, "_addr"}, mem_addr, v.addr + acks);
                chk({v.name, "_wr"}, {31'd0, mem_wr}, {31'd0, st});
                if (acks == v.hold_byte && lows < v.hold_n) begin
                    ack = 1'b0;
                    lows++;
                end else begin
                    ack = 1'b1;
                end
                if (ack && mem_wr && acks < 4) begin
                    chk({v.name, "_wdata"}, {24'd0, mem_wdata}, {24'd0, v.sdata[8*acks +: 8]});
                    tb_mem[mem_addr[11:0]] = mem_wdata;
                    wrs++;
                end
                if (ack) acks++;
            end else begin
                ack = 1'b0;
            end
            if (!stall) begin
                exp_t x;
                done = 1'b1;
                x = sb_q.pop_front();
                chk({v.name, "_stall_cycles"}, stall_n, x.stall);
                chk({v.name, "_req_cycles"}, reqs, x.reqs);
                chk({v.name, "_bytes_written"}, wrs, x.wrs);
                chk({v.name, "_wb_write"}, {31'd0, wb_write}, {31'd0, x.write});
                chk({v.name, "_fwd_valid"}, {31'd0, fwd}, {31'd0, x.fwd});
                if (x.write) begin
                    chk({v.name, "_wb_rd"}, {27'd0, wb_rd}, {27'd0, x.rd});
                    chk({v.name, "_wb_data"}, wb_data, x.data);
                end
                if (x.fwd) begin
                    chk({v.name, "_fwd_addr"}, {27'd0, fwd_addr}, {27'd0, x.rd});
                    chk({v.name, "_fwd_data"}, fwd_data, x.data);
                end
`ifdef MEM_MISALIGN_CHECK_EN
                chk({v.name, "_misalign"}, {31'd0, misalign}, {31'd0, x.misal});
`endif
                $display("txn %s cmd=%0d addr=%h stall=%0d wb=%0b data=%h",
                         v.name, v.cmd, v.addr, stall_n, wb_write, wb_data);
            end
        end
        ack = 1'b0;
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout: got=no_completion want=completion", v.name);
            void'(sb_q.pop_front());
        end
    endtask

    initial begin
        logic reached;
        int   acks;

        rst_n = 1'b0; cmd = CmdADD; alu = 32'h0000FFFF; sdata = '0; rd = 5'd5; wrd = 1'b1; ack = 1'b0;
        for (int i = 0; i < 4096; i++) tb_mem[i] = 8'h00;

        tv[0]  = mk("lw_1000",  CmdLW,   32'h00001000, 32'h0, 5'd5,  1'b1, 1'b1, 32'h12345678, -1, 0, 1'b1, 32'h12345678, 5, 4);
        tv[1]  = mk("lb_20",    CmdLB,   32'h00000020, 32'h0, 5'd6,  1'b1, 1'b1, 32'h00000080, -1, 0, 1'b1, 32'hFFFFFF80, 2, 1);
        tv[2]  = mk("lbu_20",   CmdLBU,  32'h00000020, 32'h0, 5'd6,  1'b1, 1'b1, 32'h00000080, -1, 0, 1'b1, 32'h00000080, 2, 1);
        tv[3]  = mk("lh_40",    CmdLH,   32'h00000040, 32'h0, 5'd7,  1'b1, 1'b1, 32'h00008000, -1, 0, 1'b1, 32'hFFFF8000, 3, 2);
        tv[4]  = mk("lhu_40",   CmdLHU,  32'h00000040, 32'h0, 5'd7,  1'b1, 1'b1, 32'h00008000, -1, 0, 1'b1, 32'h00008000, 3, 2);
        tv[5]  = mk("sh_2001",  CmdSH,   32'h00002001, 32'h1234ABCD, 5'd0, 1'b0, 1'b0, 32'h0, -1, 0, 1'b0, 32'h0, 3, 2);
        tv[6]  = mk("lw_hold",  CmdLW,   32'h00001000, 32'h0, 5'd8,  1'b1, 1'b1, 32'h12345678, 1, 2, 1'b1, 32'h12345678, 7, 4);
        tv[7]  = mk("addi_r0",  CmdADDI, 32'h00000055, 32'h0, 5'd0,  1'b1, 1'b0, 32'h0, -1, 0, 1'b1, 32'h00000055, 0, 0);
        tv[8]  = mk("add_r7",   CmdADD,  32'hDEADBEEF, 32'h0, 5'd7,  1'b1, 1'b0, 32'h0, -1, 0, 1'b1, 32'hDEADBEEF, 0, 0);
        tv[9]  = mk("bubble",   CmdNOP,  32'h00001234, 32'h0, 5'd3,  1'b1, 1'b0, 32'h0, -1, 0, 1'b0, 32'h0, 0, 0);
        tv[10] = mk("unknown",  6'h3F,   32'h00001234, 32'h0, 5'd3,  1'b1, 1'b0, 32'h0, -1, 0, 1'b0, 32'h0, 0, 0);
        tv[11] = mk("sw_3000",  CmdSW,   32'h00003000, 32'hCAFEBABE, 5'd0, 1'b0, 1'b0, 32'h0, -1, 0, 1'b0, 32'h0, 5, 4);
        tv[12] = mk("lw_3000",  CmdLW,   32'h00003000, 32'h0, 5'd9,  1'b1, 1'b0, 32'h0, -1, 0, 1'b1, 32'hCAFEBABE, 5, 4);
        tv[13] = mk("lw_1002",  CmdLW,   32'h00001002, 32'h0, 5'd10, 1'b1, 1'b1, 32'h44332211, -1, 0, 1'b1, 32'h44332211, 5, 4);
        tv[14] = mk("lw_wrap",  CmdLW,   32'hFFFFFFFE, 32'h0, 5'd11, 1'b1, 1'b1, 32'h89ABCDEF, -1, 0, 1'b1, 32'h89ABCDEF, 5, 4);
        tv[15] = mk("lb_pos",   CmdLB,   32'h00000021, 32'h0, 5'd12, 1'b1, 1'b1, 32'h0000007F, 0, 1, 1'b1, 32'h0000007F, 3, 1);
        tv[16] = mk("beq",      CmdBEQ,  32'h00000001, 32'h0, 5'd0,  1'b0, 1'b0, 32'h0, -1, 0, 1'b0, 32'h0, 0, 0);

        // Reset state: everything low even with a live ALU op on the inputs.
        #12;
        chk("reset_wb_write", {31'd0, wb_write}, 32'd0);
        chk("reset_wb_data", wb_data, 32'd0);
        chk("reset_stall", {31'd0, stall}, 32'd0);
        chk("reset_mem_req", {31'd0, mem_req}, 32'd0);
        chk("reset_fwd", {31'd0, fwd}, 32'd0);
`ifdef MEM_MISALIGN_CHECK_EN
        chk("reset_misalign", {31'd0, misalign}, 32'd0);
`endif
        cmd = CmdNOP;
        rst_n = 1'b1;

        for (int i = 0; i < 17; i++) apply(tv[i]);

        // Reset during byte 2 of an SW: request drops at once, access abandoned.
        @(posedge clk);
        #1;
        cmd = CmdSW; alu = 32'h00003100; sdata = 32'h11223344; rd = 5'd0; wrd = 1'b0; ack = 1'b0;
        reached = 1'b0; acks = 0;
        for (int cyc = 0; cyc < 20 && !reached; cyc++) begin
            @(negedge clk);
            if (mem_req) begin
                if (acks == 2) begin
                    reached = 1'b1;
                end else begin
                    ack = 1'b1;
                    acks++;
                end
            end
        end
        if (!reached) begin
            checks++;
            failures++;
            $display("FAIL rst_mid_sw_timeout: got=no_byte2 want=byte2");
        end
        ack = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_mem_req", {31'd0, mem_req}, 32'd0);
        chk("rst_mid_stall", {31'd0, stall}, 32'd0);
        chk("rst_mid_wb_write", {31'd0, wb_write}, 32'd0);
        #1;
        rst_n = 1'b1;
        #1;
        // Back in IDLE with the SW still presented: stall requested, no request yet.
        chk("rst_idle_state", {30'd0, mem_req, stall}, 32'd1);
        $display("txn rst_mid_sw mem_req=%0b stall=%0b", mem_req, stall);
        cmd = CmdNOP;
        @(negedge clk);
        chk("post_rst_stall", {31'd0, stall}, 32'd0);
        chk("post_rst_mem_req", {31'd0, mem_req}, 32'd0);
        chk("post_rst_wb_write", {31'd0, wb_write}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the five-stage RV32I pipeline, sitting between the EX/MEM latch and the MEM/WB latch. It executes loads and stores as byte-serial transactions on the memory controller's 8-bit port, assembling and extending load data. It produces the MEM→ID forwarding triple consumed by the decode stage, and the pipeline stall request that freezes upstream stages while an access is in flight.

## Interface
- No parameters; widths come from the shared define package (`Cmd_Typebus` = 6, `RegAddrBus` = 5, `RegBus` = 32).
- One clock; reset is asynchronous and active-low.
- `clk_in`  in  1  stage clock.
- `rst_in`  in  1  asynchronous, active-low reset.
- `cmdtype_i`  in  6  command from the EX/MEM latch; 0 is a bubble.
- `alu_result_i`  in  32  effective address for load/store; result otherwise.
- `store_data_i`  in  32  rs2 value for stores.
- `rd_i`  in  5  destination register.
- `write_rd_i`  in  1  instruction writes rd.
- `mem_req_o`  out  1  byte request valid.
- `mem_wr_o`  out  1  1 = write, 0 = read.
- `mem_addr_o`  out  32  byte address.
- `mem_wdata_o`  out  8  write byte.
- `mem_ack_i`  in  1  byte accepted; for reads, `mem_rdata_i` is valid in the same cycle.
- `mem_rdata_i`  in  8  read byte.
- `wb_write_o`  out  1  write-back enable to MEM/WB.
- `wb_rd_o`  out  5  write-back register.
- `wb_data_o`  out  32  write-back data.
- `mem_forward_id_o`  out  1  forward valid to ID.
- `mem_forward_addr_o`  out  5  forwarded register.
- `mem_forward_data_o`  out  32  forwarded value.
- `stall_from_mem_o`  out  1  freeze PC, IF/ID, ID/EX and EX/MEM.

## Operation
- FSM states: IDLE, ACCESS, DONE. A 2-bit byte counter `cnt`, a 32-bit assembly register `acc`, and `len` (1, 2 or 4 from cmdtype).
- IDLE with a non-memory cmd: combinational pass-through. `wb_*` = {`write_rd_i`, `rd_i`, `alu_result_i`}. No stall.
- IDLE with a load or store (LB/LH/LW/LBU/LHU/SB/SH/SW):
  - Assert stall.
  - Drive `wb_write_o` = 0.
  - Clear `cnt` and `acc`, then go to ACCESS.
- ACCESS:
  - `mem_req_o` = 1.
  - `mem_addr_o` = `alu_result_i` + `cnt`.
  - `mem_wdata_o` = `store_data_i[8*cnt+7:8*cnt]`.
  - Stall is held high.
  - On `mem_ack_i`: reads capture the byte into `acc[8*cnt+7:8*cnt]`; then `cnt`++.
  - On the ack with `cnt` == `len`−1, go to DONE.
  - With no ack, all outputs hold stable (wait states allowed).
- DONE:
  - Stall is low.
  - For loads, `wb_data_o` = `acc` sign-extended (LB, LH) or zero-extended (LBU, LHU) from bit 8·len−1.
  - For stores, `wb_write_o` = 0.
  - Always return to IDLE on the next edge. Upstream advances on that same edge, so DONE is never re-entered for the same instruction.
- Little-endian byte order. Address arithmetic wraps modulo 2^32.
- Forwarding: `mem_forward_id_o` = `wb_write_o` && `wb_rd_o` != 0. Address and data mirror `wb_rd_o`/`wb_data_o`. It is low in IDLE-with-mem and in ACCESS.
- Unknown cmdtype: treated as a bubble; no write-back, no request.

## Timing
- Reset values:
  - All outputs 0.
  - State IDLE.
  - `cnt` = 0 and `acc` = 0.
- Reset asserted mid-ACCESS drops `mem_req_o` asynchronously. The partial access is abandoned and no write-back occurs.
- Non-memory ops: 0 added cycles.
- N-byte access with `mem_ack_i` tied high:
  - Cycle 0: IDLE, stall high.
  - Cycles 1..N: ACCESS.
  - Cycle N+1: DONE, result valid, stall low.
  - Stall is high for N+1 cycles.
- Each cycle of `mem_ack_i` low extends ACCESS by one cycle.

## Configuration
- `MEM_MISALIGN_CHECK_EN` defined:
  - Adds output `misalign_o` (1 bit, reset 0).
  - An LH/LHU/SH with addr[0] set, or an LW/SW with addr[1:0] nonzero, goes IDLE→DONE directly with no request.
  - In that DONE cycle, `misalign_o` = 1 and `wb_write_o` = 0.
- Undefined: no port. Any alignment is serviced byte-serially.

## Structure
- Shared define package holds the `Cmd*` codes, bus-width macros, and a new `MemLen` helper mapping cmdtype to byte count.
- One natural sub-module, `load_extend`: combinational `acc`/cmdtype → 32-bit extended result.

## Test plan
- LW at 0x1000, memory bytes 0x78,0x56,0x34,0x12, ack always high → addresses 0x1000..0x1003 on cycles 1–4. Cycle 5: `wb_data_o` = 0x12345678 and forward valid for rd = 5. Stall high for 5 cycles.
- LB and LBU at 0x20, byte 0x80 → 0xFFFFFF80 and 0x00000080 respectively. LH of bytes 0x00,0x80 → 0xFFFF8000.
- SH of 0x1234ABCD to 0x2001 → write 0xCD at 0x2001, then 0xAB at 0x2002; `wb_write_o` = 0 throughout.
- LW with ack low for 2 cycles on byte 1 → `mem_addr_o` is held at base+1. Stall lasts 7 cycles and the result is correct.
- ADDI result 0x55 to rd = 0 → `wb_write_o` = 1 and `mem_forward_id_o` = 0 in the same cycle. Reset low during byte 2 of an SW → `mem_req_o` = 0 immediately and state IDLE.
- With `MEM_MISALIGN_CHECK_EN`, LW at 0x1002 → no `mem_req_o`. Next cycle: `misalign_o` = 1 and `wb_write_o` = 0.
